nios_system_sysid_ctl: RTL
==========================

NIOS_SYSTEM_SYSID_CTL -- requirements
Module: nios_system_sysid_ctl

Interface
REQ-001 SHALL have parameter ID_VALUE, default 32'h0, 32-bit system ID constant.
REQ-002 SHALL have parameter TIMESTAMP, default 32'h0, 32-bit build timestamp constant.
REQ-003 SHALL have parameter NUM_SCRATCH, default 4, count of scratch registers; legal range 1..8.
REQ-004 SHALL have port clock, input, 1, the single clock for all state.
REQ-005 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port address, input, 4, word address.
REQ-007 SHALL have port read, input, 1, read strobe.
REQ-008 SHALL have port write, input, 1, write strobe.
REQ-009 SHALL have port writedata, input, 32, write data.
REQ-010 SHALL have port byteenable, input, 4, byte lanes for writes.
REQ-011 SHALL have port readdata, output, 32, registered read data.
REQ-012 SHALL have port readdatavalid, output, 1, read response qualifier.
REQ-013 SHALL have port irq, output, 1, level interrupt.

Function
REQ-014 SHALL use this register map: 0 ID (RO), 1 TIMESTAMP (RO), 2 CAPS (RO: [3:0]=NUM_SCRATCH, [15:8]=version 8'h02), 3 CTRL (RW: bit0 cnt_en, bit1 irq_en, bit2 cnt_clr write-1 self-clearing, reads 0), 4 STATUS (bit0 match, sticky, write-1-to-clear), 5 CNT_LO (RO), 6 CNT_HI (RO snapshot), 7 CMP (RW), 8..8+NUM_SCRATCH-1 SCRATCH (RW).
REQ-015 SHALL return 0 on reads of unmapped addresses and ignore writes to them and to RO registers.
REQ-016 SHALL have a fixed read latency of 1 clock: readdatavalid high exactly one cycle after each cycle with read=1, low otherwise; readdata holds its value when readdatavalid is low.
REQ-017 SHALL apply writes to RW registers per byteenable lane only; byteenable is ignored on reads.
REQ-018 SHALL, when read and write coincide on the same address, return the pre-write value.
REQ-019 SHALL keep a 64-bit uptime counter that increments by 1 per clock while cnt_en=1 and wraps from 2^64-1 to 0 with no flag.
REQ-020 SHALL, on a read of CNT_LO, copy counter bits [63:32] from the same cycle into the CNT_HI snapshot; reads of CNT_HI return the snapshot only.
REQ-021 SHALL, on a CTRL write with bit2=1, zero the counter the next cycle, overriding any increment that cycle.
REQ-022 SHALL set STATUS.match in the cycle the counter low word equals CMP while cnt_en=1.
REQ-023 SHALL give set priority when a match and a write-1-to-clear of STATUS.match coincide.
REQ-024 SHALL drive irq = STATUS.match AND irq_en, registered, asserting one cycle after match sets.

Reset
REQ-025 SHALL asynchronously on reset_n=0 clear counter, CNT_HI snapshot, CTRL, STATUS, CMP, all SCRATCH, readdata, readdatavalid and irq to 0.
REQ-026 SHALL drop any in-flight read response on reset; no readdatavalid pulse after reset deasserts unless a new read occurs.

Structure
REQ-027 SHALL place register address constants, CTRL/STATUS bit indices and the version constant in shared package nios_system_sysid_pkg.
REQ-028 SHALL implement the 64-bit counter, snapshot and compare in one sub-module nios_system_sysid_uptime; decode and response logic in the top.

Verification
REQ-029 SHALL cover: ID_VALUE=32'h5820_5A67, read addr 0 -> readdatavalid one cycle later with readdata 32'h5820_5A67; read addr 15 -> 0.
REQ-030 SHALL cover: write SCRATCH0 32'hFFFF_FFFF then write 32'h0000_1234 with byteenable 4'b0011 -> readback 32'hFFFF_1234.
REQ-031 SHALL cover: counter forced to 64'h0000_0001_FFFF_FFFF, cnt_en=1, read CNT_LO -> 32'hFFFF_FFFF then CNT_HI -> 32'h0000_0001 despite carry.
REQ-032 SHALL cover: CMP=100, irq_en=1, cnt_clr then cnt_en -> STATUS.match set when low word equals 100, irq high next cycle; W1C at the same cycle as a new match keeps match=1.
REQ-033 SHALL cover: reset_n pulsed low in the cycle after a read -> readdatavalid, irq, CTRL, SCRATCH all 0 immediately; no stale response afterwards.

Source files
------------

// File: rtl/nios_system_sysid_pkg.sv
// Shared register map, control/status bit positions and helpers for the
// system-ID / uptime control block.
package nios_system_sysid_pkg;

    localparam logic [3:0] ADDR_ID        = 4'd0;
    localparam logic [3:0] ADDR_TIMESTAMP = 4'd1;
    localparam logic [3:0] ADDR_CAPS      = 4'd2;
    localparam logic [3:0] ADDR_CTRL      = 4'd3;
    localparam logic [3:0] ADDR_STATUS    = 4'd4;
    localparam logic [3:0] ADDR_CNT_LO    = 4'd5;
    localparam logic [3:0] ADDR_CNT_HI    = 4'd6;
    localparam logic [3:0] ADDR_CMP       = 4'd7;
    localparam logic [3:0] ADDR_SCRATCH0  = 4'd8;

    localparam int unsigned CTRL_CNT_EN  = 0;
    localparam int unsigned CTRL_IRQ_EN  = 1;
    localparam int unsigned CTRL_CNT_CLR = 2;
    localparam int unsigned STATUS_MATCH = 0;

    localparam logic [7:0] SYSID_VERSION = 8'h02;

    // Replace only the byte lanes selected by be.
    function automatic logic [31:0] be_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  be);
        logic [31:0] mask;
        for (int unsigned i = 0; i < 4; i++) begin
            mask[i*8 +: 8] = {8{be[i]}};
        end
        return (old_val & ~mask) | (new_val & mask);
    endfunction

endpackage

// File: rtl/nios_system_sysid_uptime.sv
// 64-bit free-running uptime counter with high-word snapshot and
// low-word compare against CMP.
module nios_system_sysid_uptime
    import nios_system_sysid_pkg::*;
(
    input  logic        clock,
    input  logic        reset_n,
    input  logic        cnt_en,
    input  logic        cnt_clr,
    input  logic        snap,
    input  logic [31:0] cmp,
    output logic [31:0] cnt_lo,
    output logic [31:0] cnt_hi_snap,
    output logic        match
);

    logic [63:0] cnt_q;
    logic [31:0] snap_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q  <= '0;
            snap_q <= '0;
        end else begin
            // Clear wins over the increment scheduled for the same edge.
            if (cnt_clr) begin
                cnt_q <= '0;
            end else if (cnt_en) begin
                cnt_q <= cnt_q + 64'd1;
            end
            if (snap) begin
                snap_q <= cnt_q[63:32];
            end
        end
    end

    assign cnt_lo      = cnt_q[31:0];
    assign cnt_hi_snap = snap_q;
    assign match       = cnt_en && (cnt_q[31:0] == cmp);

endmodule

// File: rtl/nios_system_sysid_ctl.sv
// System-ID control block: register decode, byte-lane writes, registered
// 1-cycle read response and match interrupt.
module nios_system_sysid_ctl
    import nios_system_sysid_pkg::*;
#(
    parameter logic [31:0] ID_VALUE    = 32'h0,
    parameter logic [31:0] TIMESTAMP   = 32'h0,
    parameter int unsigned NUM_SCRATCH = 4
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [3:0]  address,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    input  logic [3:0]  byteenable,
    output logic [31:0] readdata,
    output logic        readdatavalid,
    output logic        irq
);

    logic                   cnt_en_q;
    logic                   irq_en_q;
    logic                   match_q;
    logic [31:0]            cmp_q;
    logic [31:0]            scratch_q [NUM_SCRATCH];

    logic [31:0]            cnt_lo;
    logic [31:0]            cnt_hi_snap;
    logic                   match_ev;

    logic                   wr_ctrl;
    logic                   wr_cmp;
    logic                   status_w1c;
    logic                   cnt_clr;
    logic                   snap;
    logic [NUM_SCRATCH-1:0] wr_scratch;
    logic [31:0]            rd_mux;

    always_comb begin
        wr_ctrl    = write && (address == ADDR_CTRL);
        wr_cmp     = write && (address == ADDR_CMP);
        status_w1c = write && (address == ADDR_STATUS) && byteenable[0]
                     && writedata[STATUS_MATCH];
        cnt_clr    = wr_ctrl && byteenable[0] && writedata[CTRL_CNT_CLR];
        snap       = read && (address == ADDR_CNT_LO);
        for (int unsigned i = 0; i < NUM_SCRATCH; i++) begin
            wr_scratch[i] = write && (address == 4'(ADDR_SCRATCH0 + i));
        end
    end

    nios_system_sysid_uptime u_uptime (
        .clock       (clock),
        .reset_n     (reset_n),
        .cnt_en      (cnt_en_q),
        .cnt_clr     (cnt_clr),
        .snap        (snap),
        .cmp         (cmp_q),
        .cnt_lo      (cnt_lo),
        .cnt_hi_snap (cnt_hi_snap),
        .match       (match_ev)
    );

    always_comb begin
        rd_mux = '0;
        case (address)
            ADDR_ID:        rd_mux = ID_VALUE;
            ADDR_TIMESTAMP: rd_mux = TIMESTAMP;
            ADDR_CAPS:      rd_mux = {16'h0, SYSID_VERSION, 4'h0, 4'(NUM_SCRATCH)};
            ADDR_CTRL: begin
                rd_mux[CTRL_CNT_EN] = cnt_en_q;
                rd_mux[CTRL_IRQ_EN] = irq_en_q;
            end
            ADDR_STATUS:    rd_mux[STATUS_MATCH] = match_q;
            ADDR_CNT_LO:    rd_mux = cnt_lo;
            ADDR_CNT_HI:    rd_mux = cnt_hi_snap;
            ADDR_CMP:       rd_mux = cmp_q;
            default:        rd_mux = '0;
        endcase
        for (int unsigned i = 0; i < NUM_SCRATCH; i++) begin
            if (address == 4'(ADDR_SCRATCH0 + i)) begin
                rd_mux = scratch_q[i];
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_en_q      <= 1'b0;
            irq_en_q      <= 1'b0;
            match_q       <= 1'b0;
            cmp_q         <= '0;
            irq           <= 1'b0;
            readdata      <= '0;
            readdatavalid <= 1'b0;
            for (int unsigned i = 0; i < NUM_SCRATCH; i++) begin
                scratch_q[i] <= '0;
            end
        end else begin
            if (wr_ctrl && byteenable[0]) begin
                cnt_en_q <= writedata[CTRL_CNT_EN];
                irq_en_q <= writedata[CTRL_IRQ_EN];
            end
            if (wr_cmp) begin
                cmp_q <= be_merge(cmp_q, writedata, byteenable);
            end
            for (int unsigned i = 0; i < NUM_SCRATCH; i++) begin
                if (wr_scratch[i]) begin
                    scratch_q[i] <= be_merge(scratch_q[i], writedata, byteenable);
                end
            end

            // A new match beats a simultaneous write-1-to-clear.
            if (match_ev) begin
                match_q <= 1'b1;
            end else if (status_w1c) begin
                match_q <= 1'b0;
            end
            irq <= match_q && irq_en_q;

            readdatavalid <= read;
            if (read) begin
                readdata <= rd_mux;
            end
        end
    end

endmodule
